// File: rtl/sorted_muon_serializer.sv
// sorted_muon_serializer: two-slot ping-pong buffer after the bitonic sorter, streams the top K muons per frame.
// Optional feature macro SORTED_MUON_DROP_EMPTY_EN: trims each frame at its first all-zero candidate.
package sorted_muon_pkg;
   typedef struct packed {
      logic [3:0] qual;
      logic [8:0] pt;
      logic [9:0] eta;
      logic [8:0] phi;
   } muon_t;
endpackage

// state  | meaning
// S_IDLE | no buffered frame, out_valid low
// S_SEND | at least one frame buffered, streaming slot[rd][idx]
module sorted_muon_serializer
   import sorted_muon_pkg::*;
#(
   parameter int W = 16,
   parameter int K = 8,
   localparam int IDX_W = (K > 1) ? $clog2(K) : 1,
   localparam int LEN_W = $clog2(K + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_in_valid,
   input  muon_t            i_m [0:W-1],
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output muon_t            o_out_muon,
   output logic [IDX_W-1:0] o_out_idx,
   output logic             o_out_last,
   output logic [15:0]      o_drop_count
);

   typedef enum logic {S_IDLE, S_SEND} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   muon_t            r_buf [0:1][0:K-1];
   logic [LEN_W-1:0] r_len [0:1];
   logic [1:0]       r_occ;
   logic             r_rd;
   logic             r_wr;
   logic [IDX_W-1:0] r_idx;
   logic [15:0]      r_drop;

   logic [LEN_W-1:0] w_len;
   logic [LEN_W-1:0] w_cur_len;
   logic             w_store;
   logic             w_valid;
   logic             w_last;
   logic             w_beat;
   logic             w_pop;
   logic             w_free;
   logic             w_cap;
   logic             w_drop;
   logic [1:0]       w_occ_nxt;
   logic             w_unused_hi;

   always_comb begin : len_calc
`ifdef SORTED_MUON_DROP_EMPTY_EN
      logic run;
      run   = 1'b1;
      w_len = '0;
      for (int i = 0; i < K; i++) begin
         if (run && (i_m[i] != '0)) w_len = w_len + LEN_W'(1);
         else                       run   = 1'b0;
      end
      w_store = i_in_valid && (w_len != '0);
`else
      w_len   = LEN_W'(K);
      w_store = i_in_valid;
`endif
   end

   // candidates ranked below K are never forwarded
   always_comb begin
      w_unused_hi = 1'b0;
      for (int i = K; i < W; i++) w_unused_hi = w_unused_hi ^ (^i_m[i]);
   end

   always_comb begin
      w_cur_len   = r_len[r_rd];
      w_valid     = (r_state == S_SEND);
      w_last      = w_valid && (LEN_W'(r_idx) == (w_cur_len - LEN_W'(1)));
      w_beat      = w_valid && i_out_ready;
      w_pop       = w_beat && w_last;
      // a full buffer still accepts a frame on the edge that frees a slot
      w_free      = (r_occ != 2'd2) || w_pop;
      w_cap       = w_store && w_free;
      w_drop      = w_store && !w_free;
      w_occ_nxt   = r_occ + {1'b0, w_cap} - {1'b0, w_pop};
      w_state_nxt = (w_occ_nxt != 2'd0) ? S_SEND : S_IDLE;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_occ   <= 2'd0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
         r_idx   <= '0;
         r_drop  <= 16'd0;
      end else begin
         r_state <= w_state_nxt;
         r_occ   <= w_occ_nxt;
         if (w_cap) r_wr <= ~r_wr;
         if (w_pop) begin
            r_rd  <= ~r_rd;
            r_idx <= '0;
         end else if (w_beat) begin
            r_idx <= r_idx + IDX_W'(1);
         end
         if (w_drop && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_cap) begin
         for (int i = 0; i < K; i++) r_buf[r_wr][i] <= i_m[i];
         r_len[r_wr] <= w_len;
      end
   end

   always_comb begin
      o_out_valid  = w_valid;
      o_out_muon   = w_valid ? r_buf[r_rd][r_idx] : '0;
      o_out_idx    = r_idx;
      o_out_last   = w_last;
      o_drop_count = r_drop;
   end

endmodule

// File: doc/sorted_muon_serializer.md
# sorted_muon_serializer

Output stage placed directly after the retimed bitonic sorter. Each cycle that the sorter presents a valid frame, this block captures the W sorted `muon_t` candidates into a two-frame ping-pong buffer. It then streams the top K candidates one per cycle over a valid/ready interface to the downstream readout. The sorter pipeline cannot be stalled, so a frame that arrives while both buffers are busy is dropped and counted.

## Interface
- `W`, 16: candidates per input frame; must match the sorter width.
- `K`, 8: candidates forwarded per frame, 1 ≤ K ≤ W; slots 0..K-1 are taken, since slot 0 is the highest-ranked output of the DIR=1 sorter.
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: `m` holds a complete sorted frame this cycle.
- `m` in `muon_t [0:W-1]`: sorted frame from the sorter stage.
- `out_valid` out 1: `out_muon` is valid.
- `out_ready` in 1: downstream accepts the current beat.
- `out_muon` out `muon_t`: current candidate; forced to all-zero whenever `out_valid`=0.
- `out_idx` out `$clog2(K)`: rank of the current candidate within its frame.
- `out_last` out 1: current beat is the final beat of its frame.
- `drop_count` out 16: number of frames dropped due to overflow; saturates at 16'hFFFF.

## Operation
- Buffer: two slots, each holding K muons and a length `len` (1..K).
- Occupancy counter `occ` takes values 0..2. Read pointer `rd` and write pointer `wr` are 1 bit each.
- Capture: on `in_valid`, if a slot is free (see Timing), store `m[0:K-1]` and `len` into slot `wr`, toggle `wr`, and increment `occ`. `m[K:W-1]` is ignored.
- State machine:
  - IDLE: `occ`=0, `out_valid`=0.
  - SEND: `occ`≥1, `out_valid`=1, and `out_muon`=slot[`rd`][`idx`].
- Beat: on `out_valid && out_ready`:
  - if `idx` = `len`-1, pop the slot: toggle `rd`, decrement `occ`, set `idx`=0. The next state is IDLE if `occ` becomes 0, otherwise SEND.
  - otherwise increment `idx`.
- `out_last` = (`idx` == `len`-1) && `out_valid`.
- While `out_ready`=0 in SEND, `out_muon`, `out_idx` and `out_last` hold steady.
- Overflow: `in_valid` with no free slot discards the frame and increments `drop_count` (saturating). Buffered frames are unaffected.

## Timing
- Reset values: `out_valid`=0, `out_muon`=0, `out_idx`=0, `out_last`=0, `drop_count`=0, `occ`=0, `rd`=`wr`=0.
- Reset mid-operation discards all buffered frames; no partial frame is emitted afterwards.
- Latency: a frame captured at edge t drives its first beat with `out_valid`=1 in the cycle after t, provided the buffer was empty.
- Back-to-back frames stream with no bubble: the beat after `out_last` comes from the next slot.
- A slot counts as free at an edge if `occ`<2, or if `occ`=2 and a popping beat (`out_last` && `out_ready`) occurs at the same edge. The pop and the capture then both happen, so `occ` stays 2.
- Simultaneous capture and pop at `occ`=1 leaves `occ`=1.
- Sustained throughput: one frame per K cycles with `out_ready`=1. Frames arriving faster than that overflow once the buffer is full.
- `out_muon` is a mux of registered buffer contents; there is no combinational path from `m` or `in_valid` to any output.

## Configuration
- `SORTED_MUON_DROP_EMPTY_EN` defined:
  - at capture, `len` = the count of leading non-all-zero muons among `m[0:K-1]`.
  - a frame with `len`=0 (`m[0]` all-zero) is not stored, does not touch `occ`, and does not count as a drop.
- Undefined: `len` = K always, and every frame is stored and streamed in full, including all-zero candidates.

## Test plan
- Reset, then a single frame with `m[i]`=i+1, K=8, `out_ready`=1: `out_valid` rises 1 cycle after capture; `out_muon` = 1..8 with `out_idx` 0..7; `out_last` only on the 8th beat; returns to IDLE.
- `out_ready` toggled 1,0,0,1… during a frame: no beat is skipped or repeated; outputs hold while `out_ready`=0.
- Three frames on consecutive cycles with `out_ready`=0: the first two are buffered; the third is dropped and `drop_count`=1. After releasing `out_ready`, exactly 16 beats are emitted in frame order.
- `occ`=2 with `in_valid` coinciding with `out_last` && `out_ready`: the new frame is accepted, `drop_count` is unchanged, and `occ` stays 2.
- `rst` asserted at beat 3 of a frame: next cycle all outputs are at reset values; a subsequent frame streams from `out_idx`=0.
- With `SORTED_MUON_DROP_EMPTY_EN`: a frame with 3 non-zero leading candidates emits 3 beats with `out_last` at `out_idx`=2; an all-zero frame emits nothing and `drop_count` stays 0.
